// File: rtl/decode_stage.sv
// Decode stage of the pipelined schoolRISCV core: RV32I field/immediate decode,
// the 32x32 register file with writeback bypass, load-use stall and the ID/EX register.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pcPlus4_i,
    input  logic        flush_i,
    input  logic        ex_memRead_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        freeze_o,
    output logic        valid_o,
    output logic        illegal_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    output logic [31:0] imm_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic        legal, uses_rs1, uses_rs2;
    logic        hazard, bubble, primed;
    logic [31:0] rd1, rd2;
    logic [31:0] regs [32];

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        imm      = 32'd0;
        case (opcode)
            OP_LUI:    begin uses_rs1 = 1'b0; imm = imm_u; end
            OP_AUIPC:  begin uses_rs1 = 1'b0; imm = imm_u; end
            OP_JAL:    begin uses_rs1 = 1'b0; imm = imm_j; end
            OP_JALR:   imm = imm_i;
            OP_BRANCH: begin uses_rs2 = 1'b1; imm = imm_b; end
            OP_LOAD:   imm = imm_i;
            OP_STORE:  begin uses_rs2 = 1'b1; imm = imm_s; end
            OP_IMM:    imm = imm_i;
            OP_OP:     uses_rs2 = 1'b1;
            default:   begin legal = 1'b0; uses_rs1 = 1'b0; end
        endcase
    end

    // Same-cycle writeback is forwarded so the value is visible before the array updates.
    always_comb begin
        rd1 = 32'd0;
        rd2 = 32'd0;
        if (rs1 != 5'd0)
            rd1 = (wb_we_i && wb_rd_i == rs1) ? wb_data_i : regs[rs1];
        if (rs2 != 5'd0)
            rd2 = (wb_we_i && wb_rd_i == rs2) ? wb_data_i : regs[rs2];
    end

    assign hazard = ex_memRead_i && (ex_rd_i != 5'd0) &&
                    ((uses_rs1 && ex_rd_i == rs1) || (uses_rs2 && ex_rd_i == rs2));
    assign freeze_o = !rst && primed && !flush_i && hazard;
    assign bubble   = !primed || flush_i || hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (wb_we_i && wb_rd_i != 5'd0) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            primed    <= !rst;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            pc_o      <= 32'd0;
            pcPlus4_o <= 32'd0;
            rd1_o     <= 32'd0;
            rd2_o     <= 32'd0;
            imm_o     <= 32'd0;
            opcode_o  <= 7'd0;
            funct3_o  <= 3'd0;
            funct7_o  <= 7'd0;
            rs1_o     <= 5'd0;
            rs2_o     <= 5'd0;
            rd_o      <= 5'd0;
        end else begin
            primed    <= 1'b1;
            valid_o   <= 1'b1;
            illegal_o <= !legal;
            pc_o      <= pc_i;
            pcPlus4_o <= pcPlus4_i;
            rd1_o     <= rd1;
            rd2_o     <= rd2;
            imm_o     <= imm;
            opcode_o  <= opcode;
            funct3_o  <= funct3;
            funct7_o  <= funct7;
            rs1_o     <= rs1;
            rs2_o     <= rs2;
            rd_o      <= legal ? rd : 5'd0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: startup, bypass, hazards, flush,
// immediates, illegal opcodes and reset during a stall.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i, pc_i, pcPlus4_i;
    logic        flush_i, ex_memRead_i, wb_we_i;
    logic [4:0]  ex_rd_i, wb_rd_i;
    logic [31:0] wb_data_i;
    logic        freeze_o, valid_o, illegal_o;
    logic [31:0] pc_o, pcPlus4_o, rd1_o, rd2_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .instr_i(instr_i), .pc_i(pc_i), .pcPlus4_i(pcPlus4_i),
        .flush_i(flush_i), .ex_memRead_i(ex_memRead_i), .ex_rd_i(ex_rd_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .freeze_o(freeze_o), .valid_o(valid_o), .illegal_o(illegal_o),
        .pc_o(pc_o), .pcPlus4_o(pcPlus4_o), .rd1_o(rd1_o), .rd2_o(rd2_o),
        .imm_o(imm_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
        .funct7_o(funct7_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one posedge and settle so registered outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; instr_i = 32'd0; pc_i = 32'd0; pcPlus4_i = 32'd0;
        flush_i = 1'b0; ex_memRead_i = 1'b0; ex_rd_i = 5'd0;
        wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;

        applyStimulus();
        checkOutput("reset_valid", valid_o, 0);
        checkOutput("reset_pc", pc_o, 0);
        checkOutput("reset_rd1", rd1_o, 0);
        ex_memRead_i = 1'b1; ex_rd_i = 5'd5; instr_i = 32'h00028333;
        #1 checkOutput("reset_freeze", freeze_o, 0);
        applyStimulus();

        $display("[TB] startup");
        rst = 1'b0; ex_memRead_i = 1'b0; ex_rd_i = 5'd0;
        instr_i = 32'h00500093; pc_i = 32'h100; pcPlus4_i = 32'h104;
        applyStimulus();
        checkOutput("startup_bubble", valid_o, 0);
        applyStimulus();
        checkOutput("startup_valid", valid_o, 1);
        checkOutput("startup_rd", rd_o, 1);
        checkOutput("startup_imm", imm_o, 5);
        checkOutput("startup_rd1", rd1_o, 0);
        checkOutput("startup_opcode", opcode_o, 32'h13);
        checkOutput("startup_pc", pc_o, 32'h100);
        checkOutput("startup_pc4", pcPlus4_o, 32'h104);

        $display("[TB] bypass and x0");
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
        instr_i = 32'h00318233; pc_i = 32'h104; pcPlus4_i = 32'h108;
        applyStimulus();
        checkOutput("bypass_rd1", rd1_o, 32'hDEADBEEF);
        checkOutput("bypass_rd2", rd2_o, 32'hDEADBEEF);
        checkOutput("bypass_rd", rd_o, 4);
        checkOutput("bypass_pc", pc_o, 32'h104);
        wb_we_i = 1'b0;
        applyStimulus();
        checkOutput("array_rd1", rd1_o, 32'hDEADBEEF);
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h55; instr_i = 32'h00000233;
        applyStimulus();
        checkOutput("x0_write_rd1", rd1_o, 0);
        wb_we_i = 1'b0;
        applyStimulus();
        checkOutput("x0_read_rd1", rd1_o, 0);

        $display("[TB] load-use");
        ex_memRead_i = 1'b1; ex_rd_i = 5'd0;
        #1 checkOutput("x0_no_freeze", freeze_o, 0);
        ex_rd_i = 5'd5; instr_i = 32'h00028333;
        #1 checkOutput("lu_freeze", freeze_o, 1);
        applyStimulus();
        checkOutput("lu_bubble_valid", valid_o, 0);
        checkOutput("lu_bubble_rd", rd_o, 0);
        ex_memRead_i = 1'b0;
        #1 checkOutput("lu_release", freeze_o, 0);
        applyStimulus();
        checkOutput("lu_valid", valid_o, 1);
        checkOutput("lu_rs1", rs1_o, 5);
        checkOutput("lu_rd", rd_o, 6);
        ex_memRead_i = 1'b1; instr_i = 32'h123452B7;
        #1 checkOutput("lui_no_freeze", freeze_o, 0);
        applyStimulus();
        checkOutput("lui_imm", imm_o, 32'h12345000);
        checkOutput("lui_rd", rd_o, 5);
        ex_rd_i = 5'd2; instr_i = 32'hFE20AE23;
        #1 checkOutput("rs2_freeze", freeze_o, 1);

        $display("[TB] flush priority");
        ex_rd_i = 5'd5; instr_i = 32'h00028333; flush_i = 1'b1;
        #1 checkOutput("flush_freeze", freeze_o, 0);
        applyStimulus();
        checkOutput("flush_valid", valid_o, 0);
        checkOutput("flush_pc", pc_o, 0);
        checkOutput("flush_rs1", rs1_o, 0);
        checkOutput("flush_opcode", opcode_o, 0);
        checkOutput("flush_imm", imm_o, 0);

        $display("[TB] immediates");
        flush_i = 1'b0; ex_memRead_i = 1'b0; instr_i = 32'hFE000CE3;
        applyStimulus();
        checkOutput("beq_imm", imm_o, 32'hFFFFFFF8);
        checkOutput("beq_opcode", opcode_o, 32'h63);
        instr_i = 32'hFE20AE23;
        applyStimulus();
        checkOutput("sw_imm", imm_o, 32'hFFFFFFFC);
        checkOutput("sw_rs2", rs2_o, 2);
        checkOutput("sw_rs1", rs1_o, 1);
        checkOutput("sw_funct3", funct3_o, 2);
        instr_i = 32'hFFDFF0EF;
        applyStimulus();
        checkOutput("jal_imm", imm_o, 32'hFFFFFFFC);
        checkOutput("jal_rd", rd_o, 1);

        $display("[TB] illegal opcode");
        instr_i = 32'hFFFFFFFF;
        applyStimulus();
        checkOutput("ill_illegal", illegal_o, 1);
        checkOutput("ill_valid", valid_o, 1);
        checkOutput("ill_rd", rd_o, 0);

        $display("[TB] reset during stall");
        ex_memRead_i = 1'b1; ex_rd_i = 5'd5; instr_i = 32'h00028333;
        #1 checkOutput("stall_freeze", freeze_o, 1);
        rst = 1'b1;
        #1 checkOutput("rst_drop_freeze", freeze_o, 0);
        applyStimulus();
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_illegal", illegal_o, 0);
        checkOutput("rst_pc", pc_o, 0);
        checkOutput("rst_funct7", funct7_o, 0);
        rst = 1'b0; ex_memRead_i = 1'b0; instr_i = 32'h00318233;
        applyStimulus();
        checkOutput("post_rst_bubble", valid_o, 0);
        applyStimulus();
        checkOutput("post_rst_valid", valid_o, 1);
        checkOutput("regfile_cleared", rd1_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
